// File: rtl/lrf_axis_out_if.sv
// AXI4-Stream bus carrying fused output beats from lrf_axis_out to the downstream sink.
interface lrf_axis_out_if #(
    parameter int DATA_WIDTH = 128
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/lrf_axis_out.sv
// LRF fusion output stage: keeps the final fusion pass of each frame group, buffers it
// in a first-word fall-through FIFO and streams it out with tlast on each image's last beat.
module lrf_axis_out #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int N_FUSE_COUNT    = 4,
    parameter int FIFO_DEPTH      = 32,
    parameter int PIPELINE_DELAY  = 21,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT
) (
    input  logic                    s_axis_aclk,
    input  logic                    s_axis_aresetn,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    input  logic [N_FUSE_COUNT-1:0] in_frame_idx,
    input  logic                    emit_all,
    output logic                    pipe_ready,
    lrf_axis_out_if.master          m_axis,
    output logic                    frame_done,
    output logic                    overflow
);
    localparam int BEATS_PER_IMAGE = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int BCW             = $clog2(BEATS_PER_IMAGE);
    localparam int PW              = $clog2(FIFO_DEPTH);
    localparam int CW              = $clog2(FIFO_DEPTH + 1);

    logic [BCW-1:0]        r_beat_cnt;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_frame_done;
    logic                  r_pipe_ready;
    logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];

    logic                  w_is_last;
    logic                  w_keep;
    logic                  w_tvalid;
    logic                  w_pop;
    logic                  w_push;
    logic [CW-1:0]         w_count_next;
    logic [DATA_WIDTH:0]   w_head;

    always_comb begin
        w_is_last    = (r_beat_cnt == BCW'(BEATS_PER_IMAGE - 1));
        w_keep       = in_valid & (emit_all | (in_frame_idx == '1));
        w_tvalid     = (r_count != '0);
        w_pop        = w_tvalid & m_axis.tready;
        // A full FIFO still accepts when the head leaves in the same cycle.
        w_push       = w_keep & ((r_count < CW'(FIFO_DEPTH)) | w_pop);
        w_count_next = r_count + CW'(w_push) - CW'(w_pop);
        w_head       = w_tvalid ? r_mem[r_rd_ptr] : '0;
    end

    always_ff @(posedge s_axis_aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_is_last, in_data};
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            r_beat_cnt   <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
            r_pipe_ready <= 1'b0;
        end else begin
            if (in_valid) begin
                r_beat_cnt <= w_is_last ? '0 : r_beat_cnt + BCW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count      <= w_count_next;
            r_overflow   <= r_overflow | (w_keep & ~w_push);
            r_frame_done <= w_pop & w_head[DATA_WIDTH];
            // Free space must cover every beat still in flight in the pipeline.
            r_pipe_ready <= (CW'(FIFO_DEPTH) - w_count_next) > CW'(PIPELINE_DELAY);
        end
    end

    assign m_axis.tvalid = w_tvalid;
    assign m_axis.tdata  = w_head[DATA_WIDTH-1:0];
    assign m_axis.tlast  = w_head[DATA_WIDTH];
    assign pipe_ready    = r_pipe_ready;
    assign frame_done    = r_frame_done;
    assign overflow      = r_overflow;
endmodule
